uart_rx_deserializer: RTL
=========================

Name: uart_rx_deserializer

Overview:
- UART receiver: the serial-to-parallel counterpart of the team's UART transmitter.
- Oversamples RX_IN using a clock-enable-free prescale counter.
- Detects the start bit with glitch rejection, recovers 8 data bits LSB-first, and checks optional parity and the stop bit.
- Presents P_DATA with a one-cycle data_valid pulse; sits at the serial input of the UART datapath, opposite the TX block.

Parameters:
- DATA_W, 8, data bits per frame
- PRESC_W, 6, width of the Prescale input

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- RX_IN  input  1  serial line, idle high, asynchronous to clk
- PAR_EN  input  1  1 = frame carries a parity bit after the data bits
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- Prescale  input  PRESC_W  clk cycles per bit; legal values 8, 16, 32
- P_DATA  output  DATA_W  last good received byte
- data_valid  output  1  one-cycle pulse: P_DATA updated with a good frame
- par_err  output  1  one-cycle pulse: parity mismatch, frame dropped
- stp_err  output  1  one-cycle pulse: stop bit sampled 0, frame dropped
- busy  output  1  high while the FSM is not in IDLE

Behaviour:
- Reset (async, active-high):
  - P_DATA = 0; data_valid, par_err, stp_err, busy = 0.
  - FSM = IDLE; counters = 0.
  - Synchronizer flops = 1.
- Input path: RX_IN passes through a 2-flop synchronizer (rx_s). All references below are to rx_s.
- Latching: PAR_EN, PAR_TYP and Prescale are captured on the IDLE->START transition. Changes mid-frame are ignored. Non-legal Prescale values give undefined timing but must not lock up the FSM.
- Counters:
  - edge_cnt runs 0..P-1 within each bit, where P is the latched Prescale. It wraps to 0 and increments bit_cnt.
  - bit_cnt counts data bits 0..DATA_W-1.
- Sampling:
  - rx_s is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the 2-of-3 majority, registered at edge_cnt = P/2+2.
  - All decisions are taken at edge_cnt = P-1 using that value.
- States:
  - IDLE: busy=0. If rx_s=0, go to START with edge_cnt=0.
  - START: at edge_cnt=P-1, a sampled 0 goes to DATA. A sampled 1 is a glitch: return to IDLE with no flags.
  - DATA: at each edge_cnt=P-1, shift the sample into a shift register LSB-first. After bit DATA_W-1, go to PARITY if PAR_EN=1, otherwise go to STOP.
  - PARITY: at edge_cnt=P-1, compare the sample with the expected parity. Expected = XOR of data for even; XNOR for odd. Record the mismatch and go to STOP.
  - STOP: at edge_cnt=P-1, return to IDLE and evaluate the frame:
    - If the sample is 0: stp_err=1 for one cycle.
    - Else if parity mismatched: par_err=1 for one cycle.
    - Else: P_DATA = shift register, and data_valid=1 for one cycle.
    - Exactly one of the three pulses fires per completed frame. stp_err takes priority over par_err.
- Output hold: P_DATA holds its value across bad frames and idle.
- Latency: data_valid asserts on the clock after the STOP decision edge. From the rx_s falling edge this is (1+DATA_W+PAR_EN+1)*P cycles, plus 2 cycles of synchronizer latency.
- Back-to-back frames: IDLE is re-entered on the final STOP cycle. A start bit that immediately follows is detected on the next cycle, a 1-cycle phase skew that the mid-bit sampling tolerates.
- Line held low (break): produces stp_err. The FSM then stays in IDLE->START cycling until the line returns high, emitting stp_err once per frame time.
- Reset mid-frame: the frame is abandoned and no pulse fires. Reception resumes at the next falling edge after rst deasserts.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> data_valid pulses once, P_DATA=0xA5, par_err=stp_err=0, busy high for 80 cycles.
- Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x37 with parity bit 1 (correct) -> data_valid, P_DATA=0x37. Same byte with parity bit 0 -> par_err pulse, P_DATA unchanged.
- Prescale=32, PAR_EN=1, PAR_TYP=1, byte 0xFF with correct parity but stop bit 0 -> stp_err pulse only, no par_err, no data_valid.
- Glitch test: RX_IN low for 3 cycles at Prescale=16 -> FSM returns to IDLE, busy drops, no flags. A following valid frame 0x5A is received correctly.
- Back-to-back frames 0x00, 0xFF, 0x81 at Prescale=8 with no idle gap -> three data_valid pulses in order with the correct bytes.
- Assert rst during bit 4 of frame 0xC3 -> all outputs 0 immediately. A following frame 0x3C gives P_DATA=0x3C and a single data_valid.

Source files
------------

// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if: serial line, frame configuration and receive status bundle.
interface uart_rx_deserializer_if #(parameter int DATA_W = 8, parameter int PRESC_W = 6);
    logic RX_IN;
    logic PAR_EN;
    logic PAR_TYP;
    logic [PRESC_W-1:0] Prescale;
    logic [DATA_W-1:0] P_DATA;
    logic data_valid;
    logic par_err;
    logic stp_err;
    logic busy;
    modport master (output RX_IN, PAR_EN, PAR_TYP, Prescale, input P_DATA, data_valid, par_err, stp_err, busy);
    modport slave (input RX_IN, PAR_EN, PAR_TYP, Prescale, output P_DATA, data_valid, par_err, stp_err, busy);
endinterface

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampling UART receiver with 2-of-3 mid-bit voting,
// optional parity check and stop-bit check.
module uart_rx_deserializer #(
    parameter int DATA_W = 8,
    parameter int PRESC_W = 6
) (
    input logic clk,
    input logic rst,
    uart_rx_deserializer_if.slave bus
);
    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic rx_m, rx_s;
    logic [PRESC_W-1:0] presc, edge_cnt, half;
    logic par_en, par_typ;
    logic [BC_W-1:0] bit_cnt;
    logic [2:0] smp;
    logic bit_val, par_bad, last_edge, last_bit;
    logic [DATA_W-1:0] shreg, p_data;
    logic dv, pe, se;
    assign half = presc >> 1;
    assign last_edge = edge_cnt == presc - PRESC_W'(1);
    assign last_bit = bit_cnt == BC_W'(DATA_W - 1);
    assign bus.P_DATA = p_data;
    assign bus.data_valid = dv;
    assign bus.par_err = pe;
    assign bus.stp_err = se;
    assign bus.busy = state != IDLE;
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = rx_s ? IDLE : START;
            START: state_n = last_edge ? (bit_val ? IDLE : DATA) : START;
            DATA: state_n = (last_edge && last_bit) ? (par_en ? PARITY : STOP) : DATA;
            PARITY: state_n = last_edge ? STOP : PARITY;
            STOP: state_n = last_edge ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            state <= IDLE;
            edge_cnt <= '0;
            bit_cnt <= '0;
            presc <= '0;
            par_en <= 1'b0;
            par_typ <= 1'b0;
            smp <= '0;
            bit_val <= 1'b0;
            par_bad <= 1'b0;
            shreg <= '0;
            p_data <= '0;
            dv <= 1'b0;
            pe <= 1'b0;
            se <= 1'b0;
        end else begin
            rx_m <= bus.RX_IN;
            rx_s <= rx_m;
            state <= state_n;
            dv <= 1'b0;
            pe <= 1'b0;
            se <= 1'b0;
            edge_cnt <= (state == IDLE || last_edge) ? '0 : edge_cnt + PRESC_W'(1);
            // frame configuration is frozen at start-bit detection
            if (state == IDLE && !rx_s) begin
                presc <= bus.Prescale;
                par_en <= bus.PAR_EN;
                par_typ <= bus.PAR_TYP;
                par_bad <= 1'b0;
                bit_cnt <= '0;
            end
            if (edge_cnt == half - PRESC_W'(1)) smp[0] <= rx_s;
            if (edge_cnt == half) smp[1] <= rx_s;
            if (edge_cnt == half + PRESC_W'(1)) smp[2] <= rx_s;
            if (edge_cnt == half + PRESC_W'(2)) bit_val <= (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
            if (last_edge && state == DATA) begin
                shreg <= {bit_val, shreg[DATA_W-1:1]};
                bit_cnt <= last_bit ? '0 : bit_cnt + BC_W'(1);
            end
            if (last_edge && state == PARITY) par_bad <= bit_val != (^shreg ^ par_typ);
            // stop error outranks parity error; only clean frames update P_DATA
            if (last_edge && state == STOP) begin
                se <= !bit_val;
                pe <= bit_val & par_bad;
                dv <= bit_val & !par_bad;
                if (bit_val && !par_bad) p_data <= shreg;
            end
        end
    end
endmodule
